// File: rtl/gpu_text_renderer.sv
// gpu_text_renderer: VGA text-mode scan-out with font ROM lookup,
// 2-stage pixel pipeline and blinking block cursor.
module gpu_text_renderer #(
   parameter int H_VISIBLE    = 640,
   parameter int H_FRONT      = 16,
   parameter int H_SYNC       = 96,
   parameter int H_BACK       = 48,
   parameter int V_VISIBLE    = 480,
   parameter int V_FRONT      = 10,
   parameter int V_SYNC       = 2,
   parameter int V_BACK       = 33,
   parameter int COLS         = 80,
   parameter int ROWS         = 30,
   parameter int ADDR_WIDTH   = 12,
   parameter int BLINK_FRAMES = 30
) (
   input  logic                  CLOCK_150,
   input  logic                  reset_n,
   input  logic                  pixel_ce,
   output logic [ADDR_WIDTH-1:0] text_address,
   input  logic [7:0]            text_data,
   output logic [11:0]           font_address,
   input  logic [7:0]            font_data,
   input  logic [ADDR_WIDTH-1:0] cursor_address,
   input  logic                  cursor_enable,
   output logic                  hsync,
   output logic                  vsync,
   output logic                  video_active,
   output logic                  pixel_on,
   output logic                  frame_start
);

   localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

   localparam logic [9:0] H_LAST  = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST  = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_VIS   = 10'(H_VISIBLE);
   localparam logic [9:0] V_VIS   = 10'(V_VISIBLE);
   localparam logic [9:0] HS_LO   = 10'(H_VISIBLE + H_FRONT);
   localparam logic [9:0] HS_HI   = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
   localparam logic [9:0] VS_LO   = 10'(V_VISIBLE + V_FRONT);
   localparam logic [9:0] VS_HI   = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);
   localparam logic [9:0] V_TEXT_LAST = 10'(ROWS * 16 - 1);

   localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [FW-1:0] F_LAST = FW'(BLINK_FRAMES - 1);

   typedef struct packed {
      logic [7:0] chr;
      logic [3:0] row;
      logic [2:0] xb;
      logic       act;
      logic       hs;
      logic       vs;
      logic       hit;
      logic       first;
   } s1_t;

   logic [9:0]            h_count;
   logic [9:0]            v_count;
   logic [ADDR_WIDTH-1:0] row_base;
   logic [FW-1:0]         frame_cnt;
   logic                  blink_phase;
   logic                  visible;
   logic                  h_wrap;
   logic                  v_wrap;
   logic                  row_step;
   s1_t                   s1;

   assign visible  = (h_count < H_VIS) && (v_count < V_VIS);
   assign h_wrap   = (h_count == H_LAST);
   assign v_wrap   = h_wrap && (v_count == V_LAST);
   // next line starts a new character row still inside the text area
   assign row_step = h_wrap && (v_count < V_TEXT_LAST) &&
                     (v_count[3:0] == 4'hf);

   assign text_address = visible ?
      row_base + ADDR_WIDTH'(h_count[9:3]) : '0;
   assign font_address = {s1.chr, s1.row};

   always_ff @(posedge CLOCK_150 or negedge reset_n) begin
      if (!reset_n) begin
         h_count     <= '0;
         v_count     <= '0;
         row_base    <= '0;
         frame_cnt   <= '0;
         blink_phase <= 1'b0;
      end else if (pixel_ce) begin
         h_count <= h_wrap ? '0 : h_count + 10'd1;
         if (h_wrap)
            v_count <= v_wrap ? '0 : v_count + 10'd1;
         if (v_wrap)
            row_base <= '0;
         else if (row_step)
            row_base <= row_base + ADDR_WIDTH'(COLS);
         if (v_wrap) begin
            if (frame_cnt == F_LAST) begin
               frame_cnt   <= '0;
               blink_phase <= ~blink_phase;
            end else begin
               frame_cnt <= frame_cnt + FW'(1);
            end
         end
      end
   end

   always_ff @(posedge CLOCK_150 or negedge reset_n) begin
      if (!reset_n) begin
         s1 <= '{chr: '0, row: '0, xb: '0, act: 1'b0,
                 hs: 1'b1, vs: 1'b1, hit: 1'b0, first: 1'b0};
      end else if (pixel_ce) begin
         s1.chr   <= text_data;
         s1.row   <= v_count[3:0];
         s1.xb    <= h_count[2:0];
         s1.act   <= visible;
         s1.hs    <= !((h_count >= HS_LO) && (h_count <= HS_HI));
         s1.vs    <= !((v_count >= VS_LO) && (v_count <= VS_HI));
         s1.hit   <= cursor_enable && blink_phase &&
                     (text_address == cursor_address);
         s1.first <= (h_count == 10'd0) && (v_count == 10'd0);
      end
   end

   always_ff @(posedge CLOCK_150 or negedge reset_n) begin
      if (!reset_n) begin
         hsync        <= 1'b1;
         vsync        <= 1'b1;
         video_active <= 1'b0;
         pixel_on     <= 1'b0;
         frame_start  <= 1'b0;
      end else if (pixel_ce) begin
         hsync        <= s1.hs;
         vsync        <= s1.vs;
         video_active <= s1.act;
         pixel_on     <= s1.act && (font_data[3'd7 - s1.xb] ^ s1.hit);
         frame_start  <= s1.first;
      end else begin
         frame_start  <= 1'b0;
      end
   end

endmodule

// File: tb/tb_gpu_text_renderer.sv
// tb_gpu_text_renderer: scoreboard bench on a shrunken raster plus
// a full 640x480 instance for the row-addressing spot check.
module tb_gpu_text_renderer;

   localparam int HV = 32, HF = 2, HS = 4, HB = 2;
   localparam int HT = HV + HF + HS + HB;
   localparam int VV = 32, VF = 2, VS = 2, VB = 2;
   localparam int VT = VV + VF + VS + VB;
   localparam int COLS = 4, ROWS = 2, BF = 2;
   localparam int FULL_PT = 16 * 800 + 8;
   localparam logic [4:0] IDLE = 5'b11000;

   logic        clk = 1'b0;
   logic        reset_n = 1'b1;
   logic        pixel_ce = 1'b0;
   logic [11:0] cursor_address = 12'd0;
   logic        cursor_enable = 1'b0;

   logic [11:0] text_address, font_address;
   logic [7:0]  text_data, font_data;
   logic        hsync, vsync, video_active, pixel_on, frame_start;

   logic [11:0] ta_f, fa_f;
   logic [7:0]  td_f, fd_f;
   logic        hs_f, vs_f, va_f, po_f, fs_f;

   int          n_cmp = 0;
   int          n_bad = 0;
   logic [4:0]  q[$];
   logic [4:0]  last = IDLE;
   int          mh = 0, mv = 0, mframe = 0, pf = 0;
   bit          mblink = 1'b0;

   always #5 clk = ~clk;

   function automatic logic [7:0] rom(input logic [11:0] a);
      return a[11:4] ^ {a[3:0], a[3:0]};
   endfunction

   // off-strobe cycles present junk so stray captures show up
   assign text_data = pixel_ce ? text_address[7:0] : ~text_address[7:0];
   assign font_data = pixel_ce ? rom(font_address) : ~rom(font_address);
   assign td_f      = pixel_ce ? ta_f[7:0] : ~ta_f[7:0];
   assign fd_f      = pixel_ce ? rom(fa_f) : ~rom(fa_f);

   gpu_text_renderer #(
      .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
      .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
      .COLS(COLS), .ROWS(ROWS), .ADDR_WIDTH(12), .BLINK_FRAMES(BF)
   ) dut (
      .CLOCK_150(clk), .reset_n(reset_n), .pixel_ce(pixel_ce),
      .text_address(text_address), .text_data(text_data),
      .font_address(font_address), .font_data(font_data),
      .cursor_address(cursor_address), .cursor_enable(cursor_enable),
      .hsync(hsync), .vsync(vsync), .video_active(video_active),
      .pixel_on(pixel_on), .frame_start(frame_start)
   );

   gpu_text_renderer dut_full (
      .CLOCK_150(clk), .reset_n(reset_n), .pixel_ce(pixel_ce),
      .text_address(ta_f), .text_data(td_f),
      .font_address(fa_f), .font_data(fd_f),
      .cursor_address(cursor_address), .cursor_enable(cursor_enable),
      .hsync(hs_f), .vsync(vs_f), .video_active(va_f),
      .pixel_on(po_f), .frame_start(fs_f)
   );

   task automatic chk(input string tag, input logic [15:0] got,
                      input logic [15:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got %h want %h (h=%0d v=%0d)",
                  tag, got, exp, mh, mv);
      end
   endtask

   function automatic int m_addr();
      if (mh < HV && mv < VV)
         return (mv / 16) * COLS + mh / 8;
      return 0;
   endfunction

   function automatic logic [4:0] m_out();
      logic [11:0] a;
      logic [7:0]  fd;
      logic        act, hit, hs, vs, pix;
      a   = 12'(m_addr());
      fd  = rom({a[7:0], 4'(mv % 16)});
      act = (mh < HV) && (mv < VV);
      hit = cursor_enable && mblink && (a == cursor_address);
      hs  = !(mh >= HV + HF && mh < HV + HF + HS);
      vs  = !(mv >= VV + VF && mv < VV + VF + VS);
      pix = act && (fd[7 - (mh % 8)] ^ hit);
      return {hs, vs, act, pix, (mh == 0 && mv == 0)};
   endfunction

   task automatic m_advance();
      if (mh == HT - 1) begin
         mh = 0;
         if (mv == VT - 1) begin
            mv = 0;
            if (mframe == BF - 1) begin
               mframe = 0;
               mblink = !mblink;
            end else begin
               mframe++;
            end
         end else begin
            mv++;
         end
      end else begin
         mh++;
      end
   endtask

   task automatic step(input bit ce);
      logic [11:0] a;
      logic [4:0]  got;
      @(negedge clk);
      pixel_ce = ce;
      a = 12'(m_addr());
      if (ce) begin
         chk("text_address", 16'(text_address), 16'(a));
         q.push_back(m_out());
         if (pf == FULL_PT)
            chk("full_text_address", 16'(ta_f), 16'd81);
      end
      @(posedge clk);
      #1;
      got = {hsync, vsync, video_active, pixel_on, frame_start};
      if (ce) begin
         chk("font_address", 16'(font_address),
             16'({a[7:0], 4'(mv % 16)}));
         if (pf == FULL_PT)
            chk("full_font_address", 16'(fa_f), 16'h0510);
         last = q.pop_front();
         m_advance();
         pf++;
         chk("outputs", 16'(got), 16'(last));
      end else begin
         chk("hold", 16'(got), 16'({last[4:1], 1'b0}));
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      pixel_ce = 1'b0;
      #2 reset_n = 1'b0;
      #1;
      chk("reset_outputs",
          16'({hsync, vsync, video_active, pixel_on, frame_start}),
          16'(IDLE));
      chk("reset_text_address", 16'(text_address), 16'd0);
      chk("reset_font_address", 16'(font_address), 16'd0);
      chk("full_reset_outputs", 16'({hs_f, vs_f, va_f, po_f, fs_f}),
          16'(IDLE));
      @(posedge clk);
      #1 reset_n = 1'b1;
      mh = 0; mv = 0; mframe = 0; mblink = 1'b0; pf = 0;
      q.delete();
      q.push_back(IDLE);
      last = IDLE;
   endtask

   initial begin
      cursor_address = 12'd5;
      cursor_enable  = 1'b1;
      do_reset();
      // continuous strobes, cursor on cell 5 across several blink periods
      for (int i = 0; i < 13000; i++) step(1'b1);

      // one strobe in three, cursor beyond the text area
      cursor_address = 12'd3000;
      for (int i = 0; i < 1600; i++) begin
         step(1'b1);
         step(1'b0);
         step(1'b0);
      end

      // mid-frame asynchronous reset
      for (int i = 0; i < 2 * HT * VT && !(mh == 20 && mv == 10); i++)
         step(1'b1);
      do_reset();
      cursor_address = 12'd7;
      step(1'b1);
      step(1'b1);
      chk("first_frame_start", 16'(frame_start), 16'd1);
      for (int i = 0; i < 4000; i++) step(1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
